// File: rtl/mem_if_pkg.sv
// Shared definitions for the instruction-memory burst responder: FSM encoding,
// bus widths, line geometry and the line-to-word address helper.
package mem_if_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 32;
  localparam int LINE_OFF_W      = 5;
  localparam int WORD_OFF_W      = 2;
  localparam int BURST_BEATS_DEF = 8;
  localparam int LINE_W          = ADDR_W - LINE_OFF_W;
  localparam int WORD_W          = ADDR_W - WORD_OFF_W;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    LATENCY = 3'b010,
    SEND    = 3'b100
  } rd_state_e;

  // First word of a line: the line number with the in-line word offset zeroed.
  function automatic logic [WORD_W-1:0] line_word_base(input logic [LINE_W-1:0] line);
    return {line, {(LINE_OFF_W - WORD_OFF_W){1'b0}}};
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide backing store: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module mem_word_array #(
  parameter int WORDS  = 4096,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(WORDS)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(WORDS)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // A write to the word being read lands at the edge, so this cycle still sees old data.
  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/inst_mem_burst_rsp.sv
// Instruction memory that answers 32-byte line reads with BURST_BEATS ascending
// word beats. Optional first-beat latency is compiled in with MEM_RD_LATENCY_EN.
module inst_mem_burst_rsp
  import mem_if_pkg::*;
#(
  parameter int MEM_WORDS   = 4096,
  parameter int BURST_BEATS = BURST_BEATS_DEF,
  parameter int LAT_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_cache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_cache_rd_req_addr,
  output logic              to_cache_rd_req_ready,
  output logic              to_cache_rd_rsp_valid,
  output logic [DATA_W-1:0] to_cache_rd_rsp_data,
  output logic              to_cache_rd_rsp_last,
  input  logic              from_cache_rd_rsp_ready,
  input  logic              init_wr_en,
  input  logic [ADDR_W-1:0] init_wr_addr,
  input  logic [DATA_W-1:0] init_wr_data
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
`ifdef MEM_RD_LATENCY_EN
  localparam int LAT_W  = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
`endif

  rd_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
`ifdef MEM_RD_LATENCY_EN
  logic [LAT_W-1:0]  lat_q, lat_d;
`endif

  logic [WORD_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              beat_last;
  logic              unused_bits;

  // Control state is reset; the latched line address is plain data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

`ifdef MEM_RD_LATENCY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
    end else begin
      lat_q <= lat_d;
    end
  end
`endif

  assign beat_last = (beat_q == BEAT_W'(BURST_BEATS - 1));

  always_comb begin
    state_d               = state_q;
    beat_d                = beat_q;
    line_d                = line_q;
`ifdef MEM_RD_LATENCY_EN
    lat_d                 = lat_q;
`endif
    to_cache_rd_req_ready = 1'b0;
    to_cache_rd_rsp_valid = 1'b0;
    to_cache_rd_rsp_last  = 1'b0;
    case (state_q)
      IDLE: begin
        to_cache_rd_req_ready = 1'b1;
        if (from_cache_rd_req_valid) begin
          line_d = from_cache_rd_req_addr[ADDR_W-1:LINE_OFF_W];
          beat_d = '0;
`ifdef MEM_RD_LATENCY_EN
          lat_d   = '0;
          state_d = LATENCY;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef MEM_RD_LATENCY_EN
      LATENCY: begin
        if (lat_q == LAT_W'(LAT_CYCLES - 1)) begin
          state_d = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
`endif
      SEND: begin
        to_cache_rd_rsp_valid = 1'b1;
        to_cache_rd_rsp_last  = beat_last;
        if (from_cache_rd_rsp_ready) begin
          if (beat_last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word address may run past the array depth; only the low index bits select a word.
  assign rd_word = line_word_base(line_q) + WORD_W'(beat_q);

  mem_word_array #(
    .WORDS  (MEM_WORDS),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (init_wr_en),
    .wr_idx  (init_wr_addr[IDX_W+WORD_OFF_W-1:WORD_OFF_W]),
    .wr_data (init_wr_data),
    .rd_idx  (rd_word[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  assign to_cache_rd_rsp_data = (state_q == SEND) ? rd_data : '0;

  assign unused_bits = ^{from_cache_rd_req_addr[LINE_OFF_W-1:0], init_wr_addr, rd_word};

endmodule

// File: tb/tb_inst_mem_burst_rsp.sv
// Scoreboard bench for inst_mem_burst_rsp: requests push expected beats from a
// word-array reference model; a negedge monitor pops and compares accepted beats.
module tb_inst_mem_burst_rsp;

  localparam int MEM_WORDS   = 4096;
  localparam int BURST_BEATS = 8;
  localparam int LAT_CYCLES  = 4;
`ifdef MEM_RD_LATENCY_EN
  localparam int EXP_LAT = LAT_CYCLES + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_ready = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  beat_t       exp_q [$];
  int          hs_cyc = 0;
  bit          awaiting_first = 0;
  int          ready_mode = 0;
  int          pat = 0;

  inst_mem_burst_rsp #(
    .MEM_WORDS   (MEM_WORDS),
    .BURST_BEATS (BURST_BEATS),
    .LAT_CYCLES  (LAT_CYCLES)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .from_cache_rd_req_valid (req_valid),
    .from_cache_rd_req_addr  (req_addr),
    .to_cache_rd_req_ready   (req_ready),
    .to_cache_rd_rsp_valid   (rsp_valid),
    .to_cache_rd_rsp_data    (rsp_data),
    .to_cache_rd_rsp_last    (rsp_last),
    .from_cache_rd_rsp_ready (rsp_ready),
    .init_wr_en              (wr_en),
    .init_wr_addr            (wr_addr),
    .init_wr_data            (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: begin
          rsp_ready = (pat == 0 || pat == 3);
          pat = (pat + 1) % 4;
        end
      endcase
    end
  end

  // Monitor: checks holds while stalled, first-beat latency, and beat contents.
  bit          hold = 0;
  logic [31:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", rsp_data, hold_data);
        chk("hold_last", 32'(rsp_last), 32'(hold_last));
      end
      if (rsp_valid) begin
        chk("ready_in_send", 32'(req_ready), 32'd0);
        if (awaiting_first) begin
          chk("first_beat_latency", 32'(cyc - hs_cyc), 32'(EXP_LAT));
          awaiting_first = 0;
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual data=%h required no beat", rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", rsp_data, e.data);
            chk("beat_last", 32'(rsp_last), 32'(e.last));
          end
        end
      end
      hold      = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_last = rsp_last;
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    ref_mem[(addr >> 2) % MEM_WORDS] = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Issue one request and queue the whole line it should return.
  task automatic send_req(input logic [31:0] addr);
    int n = 0;
    beat_t b;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end else begin
      req_valid = 1'b1;
      req_addr  = addr;
      for (int i = 0; i < BURST_BEATS; i++) begin
        b.data = ref_mem[((addr / 32) * BURST_BEATS + i) % MEM_WORDS];
        b.last = (i == BURST_BEATS - 1);
        exp_q.push_back(b);
      end
      hs_cyc = cyc;
      awaiting_first = 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d beats left required=0", exp_q.size());
      exp_q.delete();
      awaiting_first = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_last", 32'(rsp_last), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < MEM_WORDS; i++) wr(32'(i * 4), $urandom);
    for (int i = 0; i < 8; i++) wr(32'h400 + 32'(i * 4), 32'h100 + 32'(i));

    // Basic line, full-rate
    ready_mode = 0;
    send_req(32'h400);
    wait_drain();

    // Stalling pattern 1,0,0,1
    ready_mode = 2;
    pat = 0;
    send_req(32'h400);
    wait_drain();

    // Offset within line ignored
    ready_mode = 0;
    send_req(32'h40C);
    wait_drain();

    // Top of array and addresses beyond the array depth
    send_req(32'(MEM_WORDS * 4 - 16));
    wait_drain();
    send_req(32'(MEM_WORDS * 4) + 32'h400);
    wait_drain();
    send_req(32'hFFFF_FFE0);
    wait_drain();

    // Reset while beat 3 is on the bus
    send_req(32'h400);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(exp_q.size() == BURST_BEATS - 3 && rsp_valid) && n < 50);
    chk("beat3_reached", 32'(exp_q.size()), 32'(BURST_BEATS - 3));
    rst = 1'b1;
    exp_q.delete();
    awaiting_first = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_last", 32'(rsp_last), 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    send_req(32'h400);
    wait_drain();

    // Randomized traffic with preload updates between bursts
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        wr($urandom & 32'hFFFF_FFFC, $urandom);
      end
      ready_mode = int'($urandom_range(0, 2));
      send_req($urandom);
      wait_drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
